// File: rtl/dtree_pkg.sv
// Decision-tree walker shared types: node entry layout, field widths and the
// node table constant.
package dtree_pkg;

    localparam int unsigned FEAT_W      = 8;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned FSEL_W      = 3;
    localparam int unsigned WM1_W       = 3;
    localparam int unsigned CLS_W       = 5;
    localparam int unsigned TABLE_DEPTH = 16;

    localparam logic [CLS_W-1:0] CLS_ERR = 5'd31;

    typedef struct packed {
        logic              leaf;
        logic [FSEL_W-1:0] feat_idx;
        logic [WM1_W-1:0]  wm1;
        logic [FEAT_W-1:0] thr;
        logic [IDX_W-1:0]  lo;
        logic [IDX_W-1:0]  hi;
        logic [CLS_W-1:0]  cls;
    } node_t;

    function automatic node_t mk_leaf(input logic [CLS_W-1:0] cls);
        node_t n;
        n      = '0;
        n.leaf = 1'b1;
        n.cls  = cls;
        return n;
    endfunction

    function automatic node_t mk_cmp(input logic [FSEL_W-1:0] feat_idx,
                                     input logic [WM1_W-1:0]  wm1,
                                     input logic [FEAT_W-1:0] thr,
                                     input logic [IDX_W-1:0]  lo,
                                     input logic [IDX_W-1:0]  hi);
        node_t n;
        n          = '0;
        n.feat_idx = feat_idx;
        n.wm1      = wm1;
        n.thr      = thr;
        n.lo       = lo;
        n.hi       = hi;
        return n;
    endfunction

    // Node 6 loops on itself for f6=0xFF; node 11 selects a nonexistent feature.
    localparam node_t NODE_TABLE [TABLE_DEPTH] = '{
        mk_cmp(3'd6, 3'd2, 8'h00, 4'd1,  4'd2),
        mk_leaf(5'd20),
        mk_cmp(3'd6, 3'd1, 8'h00, 4'd3,  4'd4),
        mk_leaf(5'd25),
        mk_cmp(3'd0, 3'd7, 8'h80, 4'd5,  4'd6),
        mk_cmp(3'd1, 3'd3, 8'hF7, 4'd7,  4'd8),
        mk_cmp(3'd6, 3'd7, 8'hFE, 4'd9,  4'd6),
        mk_leaf(5'd3),
        mk_leaf(5'd9),
        mk_cmp(3'd2, 3'd0, 8'hFE, 4'd10, 4'd11),
        mk_leaf(5'd12),
        mk_cmp(3'd7, 3'd0, 8'h00, 4'd0,  4'd0),
        mk_leaf(CLS_ERR),
        mk_leaf(CLS_ERR),
        mk_leaf(CLS_ERR),
        mk_leaf(CLS_ERR)
    };

endpackage

// File: rtl/dtree_walker_node_rom.sv
// Combinational node table lookup; unused slots hold error-class leaves.
import dtree_pkg::*;

module dtree_node_rom (
    input  logic [IDX_W-1:0] idx,
    output node_t            node
);

    assign node = NODE_TABLE[idx];

endmodule

// File: rtl/dtree_walker.sv
// Streams in one feature vector, walks the decision tree one node per cycle
// and presents the predicted class (or an abort) until consumed.
import dtree_pkg::*;

module dtree_walker #(
    parameter int unsigned N_FEAT    = 7,
    parameter int unsigned N_NODES   = 16,
    parameter int unsigned MAX_STEPS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_class,
    output logic       out_err,
    output logic       busy
);

    localparam int unsigned NODE_W = $clog2(N_NODES);
    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state, state_d;
    logic [2:0]        fcnt, fcnt_d;
    logic [NODE_W-1:0] node_idx, node_d;
    logic [STEP_W-1:0] steps, steps_d;
    logic [4:0]        cls_d;
    logic              err_d;
    logic              in_ready_d, out_valid_d, busy_d;
    logic              feat_we;

    logic [7:0]        feat_q [N_FEAT];
    node_t             cur;

    logic [7:0]        feat_sel, slice, thr_m;
    logic [2:0]        shamt;
    logic              feat_bad, take_lo, last_step, last_feat;

    dtree_node_rom u_rom (
        .idx  (IDX_W'(node_idx)),
        .node (cur)
    );

    // Shared comparator: top W bits of the selected feature against thr[W-1:0].
    always_comb begin
        feat_bad  = 32'(cur.feat_idx) >= N_FEAT;
        feat_sel  = feat_bad ? 8'h00 : feat_q[cur.feat_idx];
        shamt     = 3'd7 - cur.wm1;
        slice     = feat_sel >> shamt;
        thr_m     = cur.thr & (8'hFF >> shamt);
        take_lo   = slice <= thr_m;
        last_step = 32'(steps) == (MAX_STEPS - 1);
        last_feat = 32'(fcnt) == (N_FEAT - 1);
    end

    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        node_d  = node_idx;
        steps_d = steps;
        cls_d   = out_class;
        err_d   = out_err;
        feat_we = 1'b0;
        case (state)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    feat_we = 1'b1;
                    if (last_feat) begin
                        fcnt_d  = 3'd0;
                        node_d  = '0;
                        steps_d = '0;
                        state_d = S_WALK;
                    end else begin
                        fcnt_d = fcnt + 3'd1;
                    end
                end
            end
            S_WALK: begin
                if (cur.leaf) begin
                    cls_d   = cur.cls;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (feat_bad || last_step) begin
                    cls_d   = CLS_ERR;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    node_d  = NODE_W'(take_lo ? cur.lo : cur.hi);
                    steps_d = steps + STEP_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        in_ready_d  = state_d == S_LOAD;
        out_valid_d = state_d == S_DONE;
        busy_d      = state_d != S_LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            fcnt      <= 3'd0;
            node_idx  <= '0;
            steps     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_class <= 5'd0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            fcnt      <= fcnt_d;
            node_idx  <= node_d;
            steps     <= steps_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_class <= cls_d;
            out_err   <= err_d;
            busy      <= busy_d;
        end
    end

    // Feature storage carries no reset; a partial sample is simply overwritten.
    always_ff @(posedge clk) begin
        if (feat_we) begin
            feat_q[fcnt] <= in_data;
        end
    end

endmodule

// File: tb/tb_dtree_walker.sv
// Self-checking bench for dtree_walker: directed vectors, stall/reset
// sequences and random streams checked against a tree-walk reference model.
module tb_dtree_walker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_class;
    logic       out_err;
    logic       busy;

    always #5 clk = ~clk;

    dtree_walker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference tree, written independently from the RTL package.
    int m_leaf [16];
    int m_f    [16];
    int m_w    [16];
    int m_thr  [16];
    int m_lo   [16];
    int m_hi   [16];
    int m_cls  [16];

    function automatic void set_node(input int i, input int leaf, input int f, input int w,
                                     input int thr, input int lo, input int hi, input int cls);
        m_leaf[i] = leaf; m_f[i] = f; m_w[i] = w; m_thr[i] = thr;
        m_lo[i] = lo; m_hi[i] = hi; m_cls[i] = cls;
    endfunction

    function automatic void init_model();
        for (int i = 0; i < 16; i++) set_node(i, 1, 0, 1, 0, 0, 0, 31);
        set_node(0,  0, 6, 3, 'h00, 1,  2,  0);
        set_node(1,  1, 0, 1, 0,    0,  0,  20);
        set_node(2,  0, 6, 2, 'h00, 3,  4,  0);
        set_node(3,  1, 0, 1, 0,    0,  0,  25);
        set_node(4,  0, 0, 8, 'h80, 5,  6,  0);
        set_node(5,  0, 1, 4, 'hF7, 7,  8,  0);
        set_node(6,  0, 6, 8, 'hFE, 9,  6,  0);
        set_node(7,  1, 0, 1, 0,    0,  0,  3);
        set_node(8,  1, 0, 1, 0,    0,  0,  9);
        set_node(9,  0, 2, 1, 'hFE, 10, 11, 0);
        set_node(10, 1, 0, 1, 0,    0,  0,  12);
        set_node(11, 0, 7, 1, 0,    0,  0,  0);
    endfunction

    function automatic void ref_walk(input logic [55:0] f, output int cls, output int err,
                                     output int k);
        int n, fv, slice;
        n = 0; cls = 31; err = 1; k = 0;
        for (int v = 1; v <= 15; v++) begin
            k = v;
            if (m_leaf[n] != 0) begin
                cls = m_cls[n];
                err = 0;
                return;
            end
            if (m_f[n] >= 7) return;
            fv    = int'(f[8*m_f[n] +: 8]);
            slice = fv / (1 << (8 - m_w[n]));
            n     = (slice <= (m_thr[n] % (1 << m_w[n]))) ? m_lo[n] : m_hi[n];
        end
    endfunction

    function automatic void check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [55:0] f);
        for (int i = 0; i < 7; i++) push_byte(f[8*i +: 8]);
    endtask

    // Counts cycles from the last feature handshake until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [55:0] f;
        int          cls;
        int          err;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vector(input int i);
        int lat;
        send_sample(vecs[i].f);
        wait_result(lat);
        check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
        check($sformatf("v%0d_cls", i), int'(out_class), vecs[i].cls);
        check($sformatf("v%0d_err", i), int'(out_err), vecs[i].err);
        check($sformatf("v%0d_in_ready_done", i), int'(in_ready), 0);
        check($sformatf("v%0d_busy_done", i), int'(busy), 1);
        @(negedge clk);
        check($sformatf("v%0d_in_ready_back", i), int'(in_ready), 1);
        check($sformatf("v%0d_out_valid_back", i), int'(out_valid), 0);
    endtask

    task automatic run_stream(input int ns, input bit rand_hs);
        logic [7:0]  bq [$];
        int          ecls [$];
        int          eerr [$];
        logic [55:0] cur_s;
        int          idx, pos, nres, cyc, c, e, k, prev_cls, prev_err;
        bit          hold;
        logic [7:0]  f0, f6;
        for (int s = 0; s < ns; s++) begin
            f6 = 8'($urandom);
            f0 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                f6 = 8'hFF;
                f0 = 8'($urandom_range(8'h81, 8'hFF));
            end
            bq.push_back(f0);
            for (int b = 1; b < 6; b++) bq.push_back(8'($urandom));
            bq.push_back(f6);
        end
        idx = 0; pos = 0; nres = 0; cyc = 0; hold = 1'b0; cur_s = '0;
        prev_cls = 0; prev_err = 0;
        while (nres < ns && cyc < 5000) begin
            out_ready = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid  = (idx < bq.size()) && (!rand_hs || $urandom_range(0, 2) != 0);
            in_data   = (idx < bq.size()) ? bq[idx] : 8'h00;
            if (hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_cls", int'(out_class), prev_cls);
                check("hold_err", int'(out_err), prev_err);
            end
            if (out_valid && out_ready) begin
                if (ecls.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    check("stream_cls", int'(out_class), ecls.pop_front());
                    check("stream_err", int'(out_err), eerr.pop_front());
                end
                nres++;
            end
            hold     = out_valid && !out_ready;
            prev_cls = int'(out_class);
            prev_err = int'(out_err);
            if (in_valid && in_ready) begin
                cur_s[8*pos +: 8] = bq[idx];
                idx++;
                pos++;
                if (pos == 7) begin
                    ref_walk(cur_s, c, e, k);
                    ecls.push_back(c);
                    eerr.push_back(e);
                    pos = 0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_results", nres, ns);
        check("stream_bytes_used", idx, bq.size());
        check("stream_leftover", ecls.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        init_model();
        vecs[0] = '{56'h1F_00_00_00_00_00_00, 20, 0, 3};
        vecs[1] = '{56'h30_00_00_00_00_00_00, 25, 0, 4};
        vecs[2] = '{56'h40_00_00_00_00_00_10, 3,  0, 6};
        vecs[3] = '{56'h40_00_00_00_00_80_10, 9,  0, 6};
        vecs[4] = '{56'hFF_00_00_00_00_00_81, 31, 1, 16};
        vecs[5] = '{56'h80_00_00_00_00_00_FF, 12, 0, 7};
        vecs[6] = '{56'h80_00_00_00_80_00_FF, 31, 1, 7};
        vecs[7] = '{56'h3F_12_34_56_78_9A_BC, 25, 0, 4};
        vecs[8] = '{56'h20_FF_FF_FF_FF_FF_FF, 25, 0, 4};

        do_reset();
        check("reset_out_class", int'(out_class), 0);
        check("reset_out_err", int'(out_err), 0);
        check("reset_out_valid", int'(out_valid), 0);

        for (int i = 0; i < 9; i++) run_vector(i);

        // Consumer stalls in DONE while in_valid toggles.
        out_ready = 1'b0;
        send_sample(vecs[1].f);
        wait_result(lat);
        check("stall_lat", lat, 4);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_cls", int'(out_class), 25);
            check("stall_err", int'(out_err), 0);
            check("stall_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in_ready", int'(in_ready), 1);
        check("stall_release_valid", int'(out_valid), 0);
        run_vector(0);

        // Reset after four bytes: only the fresh sample may matter.
        for (int i = 0; i < 4; i++) push_byte(8'hFF);
        do_reset();
        run_vector(2);

        // Reset in the middle of a long walk.
        send_sample(vecs[4].f);
        repeat (5) @(negedge clk);
        check("midwalk_busy", int'(busy), 1);
        do_reset();
        check("midwalk_out_valid", int'(out_valid), 0);
        check("midwalk_busy_after", int'(busy), 0);
        run_vector(3);

        run_stream(20, 1'b0);
        run_stream(20, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtree_walker.md
DTREE_WALKER -- requirements
Module: dtree_walker

Interface
REQ-001 SHALL have parameter N_FEAT, 7, number of 8-bit features per sample.
REQ-002 SHALL have parameter N_NODES, 16, node table depth (node index 4 bits).
REQ-003 SHALL have parameter MAX_STEPS, 15, node visits allowed before abort.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  feature byte present.
REQ-007 SHALL have port in_ready  output  1  walker accepts feature byte.
REQ-008 SHALL have port in_data  input  8  feature byte, unsigned, feature 0 first.
REQ-009 SHALL have port out_valid  output  1  classification result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_class  output  5  predicted class.
REQ-012 SHALL have port out_err  output  1  walk aborted, out_class is 31.
REQ-013 SHALL have port busy  output  1  high in WALK and DONE.

Function
REQ-014 SHALL implement FSM states LOAD, WALK, DONE; LOAD after reset.
REQ-015 LOAD: in_ready=1; each cycle with in_valid&in_ready SHALL write in_data to feature register fcnt and increment fcnt (3 bits).
REQ-016 The handshake on feature N_FEAT-1 SHALL clear fcnt, set node index to 0, and enter WALK the next cycle.
REQ-017 in_ready SHALL be 0 in WALK and DONE; in_valid there SHALL be ignored and the feature registers SHALL be left unchanged.
REQ-018 Node entry fields SHALL be: leaf(1), feat_idx(3), wm1(3, slice width W=wm1+1), thr(8), lo(4), hi(4), cls(5).
REQ-019 WALK SHALL evaluate exactly one node per cycle through a single shared comparator.
REQ-020 Comparison SHALL be unsigned: slice = feature[feat_idx] >> (8-W), zero-extended; condition slice <= thr[W-1:0].
REQ-021 When the condition holds, next node SHALL be lo; otherwise next node SHALL be hi.
REQ-022 A leaf node SHALL register cls into out_class, clear out_err, and enter DONE.
REQ-023 A step counter SHALL count visited nodes; if the MAX_STEPS-th visit is not a leaf, or feat_idx>=N_FEAT, the walker SHALL set out_class=31, out_err=1 and enter DONE.
REQ-024 out_valid SHALL be 1 exactly in DONE; out_class and out_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 out_valid&out_ready SHALL return the FSM to LOAD next cycle; in_ready SHALL rise in that cycle.
REQ-026 Latency, last feature handshake to out_valid, SHALL be k+1 cycles for a k-node path, leaf included.
REQ-027 out_class and out_err SHALL be held between results; they are meaningful only when out_valid=1.

Reset
REQ-028 rst SHALL asynchronously force LOAD, fcnt=0, node=0, steps=0, out_valid=0, out_class=0, out_err=0, busy=0; in_ready=1 after release.
REQ-029 Reset mid-LOAD or mid-WALK SHALL discard the partial sample; feature register contents are don't-care.

Structure
REQ-030 Package dtree_pkg SHALL hold the node_t struct, field widths, CLS_ERR=31, and the node table constant.
REQ-031 Sub-module dtree_node_rom SHALL map a 4-bit index combinationally to node_t; unused indices SHALL return a leaf with cls=31.

Verification (default table: node0 = f6,W=3,thr=0, lo=leaf cls 20 (node1), hi=node2; node2 = f6,W=2,thr=0, lo=leaf cls 25, hi=...)
REQ-032 Bytes 0..5 = 0x00, f6 = 0x1F, out_ready=1 -> out_valid 3 cycles after last handshake, out_class=20, out_err=0.
REQ-033 f6=0x30 -> path node0->node2->leaf, out_class=25, out_valid 4 cycles after last handshake.
REQ-034 out_ready=0 for 10 cycles in DONE -> out_valid, out_class, out_err stable; in_valid pulses ignored; in_ready=0.
REQ-035 Patched table with a cycle (node0.hi=node0 for f6=0xFF) -> after 15 visits out_class=31, out_err=1.
REQ-036 rst asserted after 4 bytes, then 7 fresh bytes -> result depends only on the fresh bytes; in_ready=1 right after reset release.
REQ-037 in_valid held high continuously with out_ready=1 -> back-to-back samples, every 7 bytes yield exactly one result, no byte lost or duplicated.
